// File: rtl/read_response_tx.sv
// read_response_tx: waits for register read data after a read strobe and streams header, address and value words.
// Defining RESP_CHECKSUM_EN appends an XOR checksum word to every frame.
module read_response_tx #(
  parameter int WORD_WIDTH   = 8,
  parameter int VALUE_WORDS  = 4,
  parameter int READ_LATENCY = 1,
  parameter int RESP_HEADER  = 'h55
) (
  input  logic                              clk,
  input  logic                              i_reset_n,
  input  logic                              i_r_en,
  input  logic [WORD_WIDTH-1:0]             i_r_addr,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0] i_r_data,
  output logic [WORD_WIDTH-1:0]             o_data,
  output logic                              o_dv,
  input  logic                              i_ready,
  output logic                              o_busy,
  output logic                              o_drop
);
  localparam int VW = VALUE_WORDS * WORD_WIDTH;
  localparam int IW = $clog2(VALUE_WORDS) + 1;
  localparam logic [IW-1:0] LAST = IW'(VALUE_WORDS - 1);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  localparam logic [WORD_WIDTH-1:0] HDR = WORD_WIDTH'(RESP_HEADER);
`ifdef RESP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, WAIT_DATA, SEND_HDR, SEND_ADDR, SEND_VALUE, SEND_CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_DATA, SEND_HDR, SEND_ADDR, SEND_VALUE} state_t;
`endif
  state_t state, state_n;
  logic [WORD_WIDTH-1:0] addr_q, addr_n, word_n, val_w, tail;
  logic [VW-1:0] data_q, data_n;
  logic [IW-1:0] idx, idx_n;
  logic [2:0] lat, lat_n;
  logic xfer, dv_n;
  assign xfer = o_dv & i_ready;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    addr_n = addr_q;
    data_n = data_q;
    idx_n = idx;
    lat_n = lat;
    case (state)
      IDLE: if (i_r_en) begin
        addr_n = i_r_addr;
        if (READ_LATENCY == 0) begin
          data_n = i_r_data;
          state_n = SEND_HDR;
        end else begin
          lat_n = 3'd1;
          state_n = WAIT_DATA;
        end
      end
      WAIT_DATA: if (lat == LAT) begin
        data_n = i_r_data;
        state_n = SEND_HDR;
      end else lat_n = lat + 3'd1;
      SEND_HDR: if (xfer) state_n = SEND_ADDR;
      SEND_ADDR: if (xfer) begin
        state_n = SEND_VALUE;
        idx_n = '0;
      end
      SEND_VALUE: if (xfer) begin
`ifdef RESP_CHECKSUM_EN
        if (idx == LAST) state_n = SEND_CSUM;
`else
        if (idx == LAST) state_n = IDLE;
`endif
        else idx_n = idx + IW'(1);
      end
`ifdef RESP_CHECKSUM_EN
      SEND_CSUM: if (xfer) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end
  // value word 0 is the most-significant slice of the captured data
  always_comb begin
    val_w = '0;
    for (int k = 0; k < VALUE_WORDS; k++)
      if (IW'(k) == idx_n) val_w = data_q[(VALUE_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH];
  end
`ifdef RESP_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum;
  always_comb begin
    csum = HDR ^ addr_q;
    for (int k = 0; k < VALUE_WORDS; k++) csum = csum ^ data_q[k*WORD_WIDTH +: WORD_WIDTH];
  end
  assign tail = state_n == SEND_CSUM ? csum : '0;
`else
  assign tail = '0;
`endif
  // outputs are registered from the next state so a held word stays put under backpressure
  assign word_n = state_n == SEND_HDR ? HDR : state_n == SEND_ADDR ? addr_q : state_n == SEND_VALUE ? val_w : tail;
  assign dv_n = state >= SEND_HDR && state_n >= SEND_HDR;
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      idx <= '0;
      lat <= '0;
      o_data <= '0;
      o_dv <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      state <= state_n;
      addr_q <= addr_n;
      data_q <= data_n;
      idx <= idx_n;
      lat <= lat_n;
      o_data <= word_n;
      o_dv <= dv_n;
      o_drop <= i_r_en && state != IDLE;
    end
  end
endmodule

// File: tb/tb_read_response_tx.sv
// tb_read_response_tx: three instances (latency 1, 3, 0) share stimulus; each is checked every cycle against a frame-queue model.
module tb_read_response_tx;
`ifdef RESP_CHECKSUM_EN
  localparam int FL = 7;
`else
  localparam int FL = 6;
`endif
  logic clk = 0, rst_n = 0, en = 0, rdy = 0;
  logic [7:0] addr = 0;
  logic [31:0] rdata = 0;
  logic [7:0] od [3];
  logic [2:0] dv, busy, drop;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] lg [3][64];
  int lc [3][64];
  int ln [3] = '{0, 0, 0};
  int dn [3] = '{0, 0, 0};
  int b0 [3], d0 [3];
  int t0;
  logic [7:0] pat;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, g, a, e);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = g == 0 ? 1 : (g == 1 ? 3 : 0);
    logic [7:0] q [$];
    logic [7:0] ad;
    bit mb, mdv, mdrop;
    int age;
    read_response_tx #(.READ_LATENCY(L)) dut (
      .clk(clk), .i_reset_n(rst_n), .i_r_en(en), .i_r_addr(addr), .i_r_data(rdata),
      .o_data(od[g]), .o_dv(dv[g]), .i_ready(rdy), .o_busy(busy[g]), .o_drop(drop[g]));
    task automatic fill(input logic [31:0] d);
      q.delete();
      q.push_back(8'h55);
      q.push_back(ad);
      for (int k = 0; k < 4; k++) q.push_back(d[31-8*k -: 8]);
`ifdef RESP_CHECKSUM_EN
      q.push_back(8'h55 ^ ad ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
`endif
    endtask
    // model: a frame is a queue of words; dv rises two cycles after the data sample
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        mb = 0; mdv = 0; mdrop = 0; age = 0;
      end else begin
        mdrop = en && mb;
        if (mb) begin
          if (mdv) begin
            if (rdy) begin
              void'(q.pop_front());
              if (q.size() == 0) begin mdv = 0; mb = 0; end
            end
          end else begin
            age++;
            if (age == L) fill(rdata);
            if (age == L + 1) mdv = 1;
          end
        end else if (en) begin
          mb = 1; age = 0; ad = addr;
          if (L == 0) fill(rdata);
        end
      end
    end
    initial forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("o_dv", g, {31'b0, dv[g]}, {31'b0, mdv});
        chk("o_busy", g, {31'b0, busy[g]}, {31'b0, mb});
        chk("o_drop", g, {31'b0, drop[g]}, {31'b0, mdrop});
        if (mdv) chk("o_data", g, {24'b0, od[g]}, {24'b0, q[0]});
        if (dv[g] && rdy) begin
          if (ln[g] < 64) begin lg[g][ln[g]] = od[g]; lc[g][ln[g]] = cyc; end
          ln[g]++;
        end
        if (drop[g]) dn[g]++;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic snap;
    for (int g = 0; g < 3; g++) begin b0[g] = ln[g]; d0[g] = dn[g]; end
  endtask
  task automatic drain;
    int n = 0;
    en = 0;
    while (busy != 0 && n < 100) begin rdata = $urandom; tick; n++; end
    chk("drain_idle", 0, {29'b0, busy}, 0);
  endtask
  task automatic chk_log(input int g, input logic [63:0] e);
    chk("frame_len", g, ln[g] - b0[g], FL);
    for (int k = 0; k < FL && b0[g] + k < ln[g] && b0[g] + k < 64; k++)
      chk("frame_word", g, {24'b0, lg[g][b0[g]+k]}, {24'b0, e[63-8*k -: 8]});
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rdy = 1;
    repeat (3) tick;
    for (int g = 0; g < 3; g++) begin
      chk("rst_data", g, {24'b0, od[g]}, 0);
      chk("rst_dv", g, {31'b0, dv[g]}, 0);
      chk("rst_busy", g, {31'b0, busy[g]}, 0);
      chk("rst_drop", g, {31'b0, drop[g]}, 0);
    end
    rst_n = 1;
    repeat (2) tick;
    // basic frame, per-instance latency, and a dropped second read at T+4
    snap;
    t0 = cyc;
    en = 1; addr = 8'h12; rdata = 32'h01020304;
    tick; en = 0; rdata = 32'hDEADBEEF;
    tick; rdata = $urandom;
    tick; rdata = 32'h01020304;
    tick; en = 1; addr = 8'h34; rdata = $urandom;
    tick;
    drain;
    chk_log(0, {48'h5512DEADBEEF, 8'h65, 8'h00});
    chk_log(1, {48'h551201020304, 8'h43, 8'h00});
    chk_log(2, {48'h551201020304, 8'h43, 8'h00});
    chk("first_dv", 0, lc[0][b0[0]] - t0, 3);
    chk("first_dv", 1, lc[1][b0[1]] - t0, 5);
    chk("first_dv", 2, lc[2][b0[2]] - t0, 2);
    chk("last_dv", 0, lc[0][b0[0]+FL-1] - t0, FL + 2);
    for (int g = 0; g < 3; g++) chk("drops", g, dn[g] - d0[g], 1);
    // backpressure
    snap;
    pat = 8'b10010110;
    en = 1; addr = 8'h12;
    for (int i = 0; i < 60; i++) begin
      rdy = pat[7 - i % 8];
      rdata = i < 4 ? 32'hDEADBEEF : $urandom;
      tick;
      en = 0;
    end
    rdy = 1;
    drain;
    for (int g = 0; g < 3; g++) begin
      chk_log(g, {48'h5512DEADBEEF, 8'h65, 8'h00});
      chk("bp_drops", g, dn[g] - d0[g], 0);
    end
    // asynchronous reset while instance 0 shows value index 1
    en = 1; addr = 8'h12; rdata = 32'hDEADBEEF;
    tick; en = 0;
    repeat (5) tick;
    rst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("arst_dv", g, {31'b0, dv[g]}, 0);
      chk("arst_busy", g, {31'b0, busy[g]}, 0);
    end
    repeat (2) tick;
    rst_n = 1;
    tick;
    snap;
    en = 1; addr = 8'h07; rdata = 0;
    tick; en = 0;
    repeat (3) tick;
    drain;
    for (int g = 0; g < 3; g++) chk_log(g, {48'h550700000000, 8'h52, 8'h00});
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 4) == 0;
      addr = $urandom;
      rdata = $urandom;
      rdy = ($urandom % 3) != 0;
      rst_n = ($urandom % 400) != 0;
      tick;
    end
    rst_n = 1;
    rdy = 1;
    drain;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
